// File: rtl/bcd_sat_conv_pkg.sv
// rtl/bcd_sat_conv_pkg.sv - shared types and constants for the BCD saturating converter
//
// Purpose: FSM state encoding, double-dabble adjust constants and a helper
// that computes the displayable maximum, limited to what the binary input
// width can represent.
// Ports: none (package).

package bcd_sat_conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OP   = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] BCD_ADJ    = 4'd3;
  localparam logic [3:0] ADJ_THRESH = 4'd5;

  // Returns min(10^digits - 1, 2^bin_w - 1). When the decimal maximum does
  // not fit in bin_w bits the result is the all-ones input value, so a
  // "bin > max" comparison can never be true and the clamp stays inactive.
  function automatic longint unsigned bcd_max_w(input int digits, input int bin_w);
    longint unsigned m;
    longint unsigned lim;
    m = 1;
    for (int i = 0; i < digits; i++) begin
      m = m * 10;
    end
    m = m - 1;
    lim = (bin_w >= 64) ? {64{1'b1}} : ((64'd1 << bin_w) - 64'd1);
    return (m > lim) ? lim : m;
  endfunction

endpackage

// File: rtl/bcd_sat_conv_if.sv
// rtl/bcd_sat_conv_if.sv - start/done and result bundle of the BCD saturating converter
//
// Purpose: groups the request (start, bin) and result (ready, done_tick,
// bcd, blank, ovf) signals.
// Modports: master drives start/bin and observes results; slave is the
// converter side.

interface bcd_sat_conv_if #(
  parameter int BIN_W  = 20,
  parameter int DIGITS = 4
);

  logic                  start;
  logic [BIN_W-1:0]      bin;
  logic                  ready;
  logic                  done_tick;
  logic [4*DIGITS-1:0]   bcd;
  logic [DIGITS-1:0]     blank;
  logic                  ovf;

  modport master (
    output start, bin,
    input  ready, done_tick, bcd, blank, ovf
  );

  modport slave (
    input  start, bin,
    output ready, done_tick, bcd, blank, ovf
  );

endinterface

// File: rtl/bcd_sat_conv_dd_digit_adj.sv
// rtl/bcd_sat_conv_dd_digit_adj.sv - double-dabble per-digit "add 3 if >= 5" step
//
// Purpose: combinational pre-shift correction for one BCD digit.
// Ports: din  - current 4-bit digit
//        dout - corrected digit (din + 3 when din >= 5, else din)

module dd_digit_adj
  import bcd_sat_conv_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // Valid digits are 0..9, so din + 3 never exceeds 12 and fits in 4 bits.
  assign dout = (din >= ADJ_THRESH) ? (din + BCD_ADJ) : din;

endmodule

// File: rtl/bcd_sat_conv.sv
// rtl/bcd_sat_conv.sv - sequential double-dabble binary-to-BCD converter with saturation
//
// Purpose: converts an unsigned BIN_W-bit value into DIGITS packed BCD
// digits, one shift per cycle. Values above 10^DIGITS-1 clamp to all
// nines and raise ovf. A per-digit blank mask flags leading zeros.
// Ports: clk       - system clock
//        reset     - synchronous active-high reset
//        io.start  - conversion request, honoured only while ready
//        io.bin    - binary input, sampled with start
//        io.ready  - high in IDLE
//        io.done_tick - one-cycle pulse when new results are valid
//        io.bcd / io.blank / io.ovf - registered results, held between conversions

module bcd_sat_conv
  import bcd_sat_conv_pkg::*;
#(
  parameter int BIN_W  = 20,
  parameter int DIGITS = 4
) (
  input  logic            clk,
  input  logic            reset,
  bcd_sat_conv_if.slave   io
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  localparam logic [BIN_W-1:0]  MAX_W     = BIN_W'(bcd_max_w(DIGITS, BIN_W));
  localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(BIN_W);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(1);
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

  state_t             state_q, state_d;
  logic [BCD_W-1:0]   acc_q, acc_d;
  logic [BIN_W-1:0]   val_q, val_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_next_q, ovf_next_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [DIGITS-1:0]  blank_q, blank_d;
  logic               ovf_q, ovf_d;

  logic [BCD_W-1:0]   acc_adj;
  logic [SR_W-1:0]    sr_shift;
  logic [BCD_W-1:0]   sh_acc;
  logic [BIN_W-1:0]   sh_val;
  logic [DIGITS-1:0]  blank_new;
  logic               zero_above;
  logic               in_ovf;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    dd_digit_adj u_adj (
      .din  (acc_q[4*g +: 4]),
      .dout (acc_adj[4*g +: 4])
    );
  end

  // Adjust every digit first, then shift the whole {acc, val} chain.
  assign sr_shift = {acc_adj, val_q} << 1;
  assign sh_acc   = sr_shift[SR_W-1 -: BCD_W];
  assign sh_val   = sr_shift[BIN_W-1:0];

  assign in_ovf   = (io.bin > MAX_W);

  // A digit is blanked only if it and every more significant digit are zero;
  // digit 0 always shows so a zero result still displays "0".
  always_comb begin
    blank_new  = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above   = zero_above & (sh_acc[4*i +: 4] == 4'd0);
      blank_new[i] = zero_above;
    end
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    val_d      = val_q;
    cnt_d      = cnt_q;
    ovf_next_d = ovf_next_q;
    bcd_d      = bcd_q;
    blank_d    = blank_q;
    ovf_d      = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (io.start) begin
          val_d      = in_ovf ? MAX_W : io.bin;
          ovf_next_d = in_ovf;
          acc_d      = '0;
          cnt_d      = CNT_LOAD;
          state_d    = ST_OP;
        end
      end
      ST_OP: begin
        acc_d = sh_acc;
        val_d = sh_val;
        cnt_d = cnt_q - CNT_LAST;
        // Final shift: publish results on this edge so the outputs jump
        // straight from the previous result to the new one.
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
          bcd_d   = sh_acc;
          blank_d = blank_new;
          ovf_d   = ovf_next_q;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      val_q      <= '0;
      cnt_q      <= '0;
      ovf_next_q <= 1'b0;
      bcd_q      <= '0;
      blank_q    <= BLANK_RST;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      val_q      <= val_d;
      cnt_q      <= cnt_d;
      ovf_next_q <= ovf_next_d;
      bcd_q      <= bcd_d;
      blank_q    <= blank_d;
      ovf_q      <= ovf_d;
    end
  end

  assign io.ready     = (state_q == ST_IDLE);
  assign io.done_tick = (state_q == ST_DONE);
  assign io.bcd       = bcd_q;
  assign io.blank     = blank_q;
  assign io.ovf       = ovf_q;

endmodule

// File: tb/tb_bcd_sat_conv.sv
// tb/tb_bcd_sat_conv.sv - self-checking bench for bcd_sat_conv

module tb_bcd_sat_conv;

  logic clk;
  logic reset;

  bcd_sat_conv_if #(.BIN_W(20), .DIGITS(4)) bus ();

  bcd_sat_conv #(.BIN_W(20), .DIGITS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  typedef struct {
    logic [19:0] bin;
    logic [15:0] bcd;
    logic [3:0]  blank;
    logic        ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: clamp, then decimal digits by division; a digit i>=1 is
  // blank exactly when the value is below 10^i.
  task automatic model(input logic [19:0] b, output logic [15:0] bcd,
                       output logic [3:0] blank, output logic ovf);
    int v;
    int p;
    v     = int'(b);
    ovf   = (v > 9999);
    if (ovf) v = 9999;
    p     = 1;
    bcd   = '0;
    blank = '0;
    for (int i = 0; i < 4; i++) begin
      bcd[4*i +: 4] = 4'((v / p) % 10);
      if (i >= 1) blank[i] = (v < p);
      p = p * 10;
    end
  endtask

  // Starts one conversion and returns at #1 after the edge showing done_tick.
  // lat counts edges from the sampling edge (1) up to the done edge.
  task automatic convert(input logic [19:0] b, output int lat, output bit ready_low);
    int guard;
    guard = 0;
    while (!bus.ready && guard < 60) begin
      @(posedge clk); #1; guard++;
    end
    @(negedge clk);
    bus.start = 1'b1;
    bus.bin   = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.bin   = 20'($urandom);
    lat       = 1;
    ready_low = !bus.ready;
    while (!bus.done_tick && lat < 60) begin
      @(posedge clk); #1;
      lat++;
      if (bus.ready) ready_low = 1'b0;
    end
  endtask

  initial begin
    int          lat;
    bit          rl;
    logic [15:0] e_bcd;
    logic [3:0]  e_blank;
    logic        e_ovf;
    logic [19:0] rb;
    int          done_at[$];
    int          seen;

    checks = 0;
    errors = 0;

    vecs[0] = '{20'd1234,    16'h1234, 4'b0000, 1'b0};
    vecs[1] = '{20'd0,       16'h0000, 4'b1110, 1'b0};
    vecs[2] = '{20'd7,       16'h0007, 4'b1110, 1'b0};
    vecs[3] = '{20'd45,      16'h0045, 4'b1100, 1'b0};
    vecs[4] = '{20'd9999,    16'h9999, 4'b0000, 1'b0};
    vecs[5] = '{20'd10000,   16'h9999, 4'b0000, 1'b1};
    vecs[6] = '{20'hFFFFF,   16'h9999, 4'b0000, 1'b1};
    vecs[7] = '{20'd5,       16'h0005, 4'b1110, 1'b0};
    vecs[8] = '{20'd100,     16'h0100, 4'b1000, 1'b0};
    vecs[9] = '{20'd999,     16'h0999, 4'b1000, 1'b0};

    bus.start = 1'b0;
    bus.bin   = '0;
    reset     = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_done",  32'(bus.done_tick), 32'd0);
    check("rst_bcd",   32'(bus.bcd), 32'h0000);
    check("rst_blank", 32'(bus.blank), 32'b1110);
    check("rst_ovf",   32'(bus.ovf), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int k = 0; k < 10; k++) begin
      convert(vecs[k].bin, lat, rl);
      check($sformatf("vec%0d_lat", k),   32'(lat), 32'd21);
      check($sformatf("vec%0d_rdy", k),   32'(rl), 32'd1);
      check($sformatf("vec%0d_bcd", k),   32'(bus.bcd), 32'(vecs[k].bcd));
      check($sformatf("vec%0d_blank", k), 32'(bus.blank), 32'(vecs[k].blank));
      check($sformatf("vec%0d_ovf", k),   32'(bus.ovf), 32'(vecs[k].ovf));
      @(posedge clk); #1;
      check($sformatf("vec%0d_pulse", k), 32'(bus.done_tick), 32'd0);
      check($sformatf("vec%0d_idle", k),  32'(bus.ready), 32'd1);
      check($sformatf("vec%0d_hold", k),  32'(bus.bcd), 32'(vecs[k].bcd));
    end

    // start with a different bin during OP must be ignored
    @(negedge clk);
    bus.start = 1'b1;
    bus.bin   = 20'd1234;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done_tick && lat < 60) begin
      @(negedge clk);
      bus.start = (lat >= 3 && lat <= 12);
      bus.bin   = 20'd777;
      @(posedge clk); #1;
      lat++;
    end
    bus.start = 1'b0;
    check("ignore_lat", 32'(lat), 32'd21);
    check("ignore_bcd", 32'(bus.bcd), 32'h1234);
    @(posedge clk); #1;
    check("ignore_idle", 32'(bus.ready), 32'd1);

    // start held high: one result every 22 cycles
    @(negedge clk);
    bus.start = 1'b1;
    bus.bin   = 20'd321;
    for (int c = 1; c <= 80; c++) begin
      @(posedge clk); #1;
      if (bus.done_tick) done_at.push_back(c);
    end
    @(negedge clk);
    bus.start = 1'b0;
    check("held_count", 32'(done_at.size() >= 3), 32'd1);
    if (done_at.size() >= 3) begin
      check("held_first", 32'(done_at[0]), 32'd21);
      check("held_gap1",  32'(done_at[1] - done_at[0]), 32'd22);
      check("held_gap2",  32'(done_at[2] - done_at[1]), 32'd22);
    end
    check("held_bcd", 32'(bus.bcd), 32'h0321);

    // leave ovf set so the reset check below is meaningful
    convert(20'd10000, lat, rl);
    check("pre_rst_ovf", 32'(bus.ovf), 32'd1);

    // reset in OP cycle 10 discards the conversion
    @(negedge clk);
    bus.start = 1'b1;
    bus.bin   = 20'd4321;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_ready", 32'(bus.ready), 32'd1);
    check("midrst_done",  32'(bus.done_tick), 32'd0);
    check("midrst_bcd",   32'(bus.bcd), 32'h0000);
    check("midrst_blank", 32'(bus.blank), 32'b1110);
    check("midrst_ovf",   32'(bus.ovf), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (bus.done_tick) seen++;
    end
    check("midrst_nodone", 32'(seen), 32'd0);
    check("midrst_keep",   32'(bus.bcd), 32'h0000);
    convert(20'd88, lat, rl);
    check("after_rst_lat", 32'(lat), 32'd21);
    check("after_rst_bcd", 32'(bus.bcd), 32'h0088);

    // randomized against the arithmetic model
    for (int r = 0; r < 40; r++) begin
      case ($urandom_range(0, 3))
        0:       rb = 20'($urandom_range(0, 99));
        1:       rb = 20'($urandom_range(0, 9999));
        2:       rb = 20'($urandom_range(9990, 10010));
        default: rb = 20'($urandom);
      endcase
      model(rb, e_bcd, e_blank, e_ovf);
      convert(rb, lat, rl);
      check($sformatf("rnd%0d_lat bin=%0d", r, rb),   32'(lat), 32'd21);
      check($sformatf("rnd%0d_bcd bin=%0d", r, rb),   32'(bus.bcd), 32'(e_bcd));
      check($sformatf("rnd%0d_blank bin=%0d", r, rb), 32'(bus.blank), 32'(e_blank));
      check($sformatf("rnd%0d_ovf bin=%0d", r, rb),   32'(bus.ovf), 32'(e_ovf));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
